// File: rtl/code_patch_cfg_ctrl.sv
// Configuration controller for the code patch datapath: a shadow bank that is committed to the active
// outputs once the slave read bus has been quiet. Optional sticky LOCK bit: define CODE_PATCH_CFG_LOCK_EN.
module code_patch_cfg_ctrl #(
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int NUM_REGS            = 8,
    parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
    parameter int QUIET_CYCLES        = 2,
    parameter int CFG_AW              = $clog2(2*NUM_REGS+2)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         cfg_req_i,
    input  logic                                         cfg_we_i,
    input  logic [CFG_AW-1:0]                            cfg_addr_i,
    input  logic [SUB_REGS_DATA_WIDTH-1:0]               cfg_wdata_i,
    output logic [SUB_REGS_DATA_WIDTH-1:0]               cfg_rdata_o,
    output logic                                         cfg_ack_o,
    input  logic                                         si_read_i,
    output logic [NUM_REGS-1:0][ADDR_WIDTH-1:0]          ctl_pat_addr_o,
    output logic [NUM_REGS-1:0][SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_o,
    output logic [NUM_REGS-1:0]                          ctl_pat_pen_o,
    output logic [NUM_REGS-1:0]                          ctl_pat_nopg_o,
    output logic                                         cfg_pat_gen_o,
    output logic                                         cfg_addr_or_data_o,
    output logic                                         commit_pending_o,
    output logic                                         commit_done_o
);

    localparam int                SW         = SUB_REGS_DATA_WIDTH;
    localparam logic [CFG_AW-1:0] CTRL_IDX   = CFG_AW'(2*NUM_REGS);
    localparam logic [CFG_AW-1:0] ENABLE_IDX = CFG_AW'(2*NUM_REGS+1);
    localparam logic [7:0]        QUIET_LAST = 8'(QUIET_CYCLES-1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_QUIET, S_COMMIT} state_t;

    state_t     state, state_nx;
    logic [7:0] quiet_cnt, quiet_cnt_nx;
    logic       do_commit;

    logic [NUM_REGS-1:0][ADDR_WIDTH-1:0] sh_addr;
    logic [NUM_REGS-1:0][SW-1:0]         sh_data;
    logic [NUM_REGS-1:0]                 sh_pen, sh_nopg;
    logic                                sh_gen, sh_aod;

    logic          locked, pending, access, wr_en, ctrl_wr, commit_wr;
    logic [SW-1:0] rd_val;

    // Handshake: an access is accepted on any edge where cfg_req_i is high and cfg_ack_o is low;
    // cfg_ack_o is high for exactly the following cycle, carrying read data, and a request still
    // held during that ack cycle is only taken again on the edge after it.
    assign access    = cfg_req_i && !cfg_ack_o;
    assign wr_en     = access && cfg_we_i && !locked;
    assign ctrl_wr   = wr_en && (cfg_addr_i == CTRL_IDX);
    assign commit_wr = ctrl_wr && cfg_wdata_i[2];
    assign pending   = (state != S_IDLE);
    assign commit_pending_o = pending;

`ifdef CODE_PATCH_CFG_LOCK_EN
    logic lock_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (ctrl_wr && cfg_wdata_i[3]) begin
            lock_q <= 1'b1;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_addr <= '0;
            sh_data <= '0;
            sh_pen  <= '0;
            sh_nopg <= '0;
            sh_gen  <= 1'b0;
            sh_aod  <= 1'b0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (cfg_addr_i == CFG_AW'(2*i)) begin
                    sh_addr[i] <= cfg_wdata_i[ADDR_WIDTH-1:0];
                end
                if (cfg_addr_i == CFG_AW'(2*i+1)) begin
                    sh_data[i] <= cfg_wdata_i;
                end
            end
            if (cfg_addr_i == CTRL_IDX) begin
                sh_gen <= cfg_wdata_i[0];
                sh_aod <= cfg_wdata_i[1];
            end
            if (cfg_addr_i == ENABLE_IDX) begin
                sh_pen  <= cfg_wdata_i[NUM_REGS-1:0];
                sh_nopg <= cfg_wdata_i[2*NUM_REGS-1:NUM_REGS];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cfg_addr_i == CFG_AW'(2*i)) begin
                rd_val = SW'(sh_addr[i]);
            end
            if (cfg_addr_i == CFG_AW'(2*i+1)) begin
                rd_val = sh_data[i];
            end
        end
        if (cfg_addr_i == CTRL_IDX) begin
            rd_val = SW'({locked, pending, sh_aod, sh_gen});
        end
        if (cfg_addr_i == ENABLE_IDX) begin
            rd_val = SW'({sh_nopg, sh_pen});
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg_ack_o   <= 1'b0;
            cfg_rdata_o <= '0;
        end else begin
            cfg_ack_o   <= access;
            cfg_rdata_o <= (access && !cfg_we_i) ? rd_val : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            quiet_cnt <= '0;
        end else begin
            state     <= state_nx;
            quiet_cnt <= quiet_cnt_nx;
        end
    end

    // The counter holds the number of quiet cycles already seen, so the cycle that would
    // make it reach QUIET_CYCLES moves straight to S_COMMIT.
    always_comb begin
        state_nx     = state;
        quiet_cnt_nx = quiet_cnt;
        do_commit    = 1'b0;
        case (state)
            S_IDLE: begin
                quiet_cnt_nx = '0;
                if (commit_wr) begin
                    state_nx = S_WAIT_QUIET;
                end
            end
            S_WAIT_QUIET: begin
                if (si_read_i) begin
                    quiet_cnt_nx = '0;
                end else if (quiet_cnt >= QUIET_LAST) begin
                    quiet_cnt_nx = '0;
                    state_nx     = S_COMMIT;
                end else begin
                    quiet_cnt_nx = quiet_cnt + 8'd1;
                end
            end
            S_COMMIT: begin
                do_commit    = 1'b1;
                quiet_cnt_nx = '0;
                state_nx     = S_IDLE;
            end
            default: begin
                quiet_cnt_nx = '0;
                state_nx     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctl_pat_addr_o     <= '0;
            ctl_pat_data_o     <= '0;
            ctl_pat_pen_o      <= '0;
            ctl_pat_nopg_o     <= '0;
            cfg_pat_gen_o      <= 1'b0;
            cfg_addr_or_data_o <= 1'b0;
            commit_done_o      <= 1'b0;
        end else begin
            commit_done_o <= do_commit;
            if (do_commit) begin
                ctl_pat_addr_o     <= sh_addr;
                ctl_pat_data_o     <= sh_data;
                ctl_pat_pen_o      <= sh_pen;
                ctl_pat_nopg_o     <= sh_nopg;
                cfg_pat_gen_o      <= sh_gen;
                cfg_addr_or_data_o <= sh_aod;
            end
        end
    end

endmodule

// File: tb/tb_code_patch_cfg_ctrl.sv
// Self-checking bench for code_patch_cfg_ctrl: vector table, directed commit sequences and
// randomized accesses checked against an array-based register model.
module tb_code_patch_cfg_ctrl;

    localparam int NR   = 8;
    localparam int AW   = 32;
    localparam int SW   = 32;
    localparam int CAW  = 5;
    localparam int ACTW = NR*AW + NR*SW + 2*NR + 2;

    logic                   clk = 1'b0;
    logic                   rst_ni;
    logic                   cfg_req;
    logic                   cfg_we;
    logic [CAW-1:0]         cfg_addr;
    logic [SW-1:0]          cfg_wdata;
    logic [SW-1:0]          cfg_rdata;
    logic                   cfg_ack;
    logic                   si_read;
    logic [NR-1:0][AW-1:0]  ctl_pat_addr;
    logic [NR-1:0][SW-1:0]  ctl_pat_data;
    logic [NR-1:0]          ctl_pat_pen;
    logic [NR-1:0]          ctl_pat_nopg;
    logic                   pat_gen;
    logic                   addr_or_data;
    logic                   commit_pending;
    logic                   commit_done;

    code_patch_cfg_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR),
        .SUB_REGS_DATA_WIDTH(SW), .QUIET_CYCLES(2), .CFG_AW(CAW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata), .cfg_ack_o(cfg_ack),
        .si_read_i(si_read),
        .ctl_pat_addr_o(ctl_pat_addr), .ctl_pat_data_o(ctl_pat_data),
        .ctl_pat_pen_o(ctl_pat_pen), .ctl_pat_nopg_o(ctl_pat_nopg),
        .cfg_pat_gen_o(pat_gen), .cfg_addr_or_data_o(addr_or_data),
        .commit_pending_o(commit_pending), .commit_done_o(commit_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_addr[NR], m_data[NR], a_addr[NR], a_data[NR];
    logic [7:0]  m_pen, m_nopg, a_pen, a_nopg;
    logic        m_gen, m_aod, m_lock, a_gen, a_aod;

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_addr[i] = '0; m_data[i] = '0; a_addr[i] = '0; a_data[i] = '0;
        end
        m_pen = '0; m_nopg = '0; a_pen = '0; a_nopg = '0;
        m_gen = 1'b0; m_aod = 1'b0; m_lock = 1'b0; a_gen = 1'b0; a_aod = 1'b0;
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [31:0] w);
        if (m_lock && a < 5'd18) return;
        if (a < 5'd16) begin
            if (a[0]) m_data[a[3:1]] = w;
            else      m_addr[a[3:1]] = w;
        end else if (a == 5'd16) begin
            m_gen = w[0];
            m_aod = w[1];
`ifdef CODE_PATCH_CFG_LOCK_EN
            m_lock = m_lock | w[3];
`endif
        end else if (a == 5'd17) begin
            m_pen  = w[7:0];
            m_nopg = w[15:8];
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic pend);
        if (a < 5'd16) return a[0] ? m_data[a[3:1]] : m_addr[a[3:1]];
        if (a == 5'd16) return {28'd0, m_lock, pend, m_aod, m_gen};
        if (a == 5'd17) return {16'd0, m_nopg, m_pen};
        return 32'd0;
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < NR; i++) begin
            a_addr[i] = m_addr[i];
            a_data[i] = m_data[i];
        end
        a_pen = m_pen; a_nopg = m_nopg; a_gen = m_gen; a_aod = m_aod;
    endfunction

    task automatic check_active(input string tag);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(ctl_pat_addr[i]), 64'(a_addr[i]));
            check($sformatf("%s_data%0d", tag, i), 64'(ctl_pat_data[i]), 64'(a_data[i]));
        end
        check({tag, "_pen"},  64'(ctl_pat_pen),  64'(a_pen));
        check({tag, "_nopg"}, 64'(ctl_pat_nopg), 64'(a_nopg));
        check({tag, "_gen"},  64'(pat_gen),      64'(a_gen));
        check({tag, "_aod"},  64'(addr_or_data), 64'(a_aod));
    endtask

    // ---------------- monitor ----------------
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       rst_prev = 1'b0;
    logic [ACTW-1:0] act_now, act_prev;
    assign act_now = {ctl_pat_addr, ctl_pat_data, ctl_pat_pen, ctl_pat_nopg, pat_gen, addr_or_data};

    always @(negedge clk) begin
        if (rst_prev && rst_ni) begin
            n_cmp++;
            if (act_now !== act_prev && commit_done !== 1'b1) begin
                n_fail++;
                $display("FAIL active_stable: outputs changed at cycle %0d with commit_done=%b, required unchanged",
                         cyc, commit_done);
            end
        end
        if (cfg_ack === 1'b0) check("rdata_idle", 64'(cfg_rdata), 64'd0);
        if (commit_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        act_prev = act_now;
        rst_prev = rst_ni;
    end

    // ---------------- driver tasks ----------------
    int last_ack_cyc = 0;

    task automatic cfg_access(input logic we, input logic [4:0] a, input logic [31:0] wd,
                              output logic [31:0] rd);
        int lat;
        lat = 0;
        cfg_req = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        do begin
            @(negedge clk);
            lat++;
        end while (cfg_ack !== 1'b1 && lat < 4);
        check("ack_latency", 64'(lat), 64'd1);
        last_ack_cyc = cyc;
        rd = cfg_rdata;
        cfg_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] wd);
        logic [31:0] d;
        cfg_access(1'b1, a, wd, d);
        model_write(a, wd);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        cfg_access(1'b0, a, 32'd0, d);
        check(name, 64'(d), 64'(exp));
    endtask

    task automatic wait_done(input int start, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 64'(done_cnt != start), 64'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [4:0] a, input logic [31:0] w,
                                input logic [31:0] e);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = w; v.exp = e;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        int          start, ack_c, fall_c;
        logic [4:0]  ra;
        logic [31:0] rw;

        vq.push_back(mk(1'b1, 5'd6,  32'h0000_1000, 32'h0));
        vq.push_back(mk(1'b0, 5'd6,  32'h0,         32'h0000_1000));
        vq.push_back(mk(1'b1, 5'd7,  32'h0000_CAFE, 32'h0));
        vq.push_back(mk(1'b0, 5'd7,  32'h0,         32'h0000_CAFE));
        vq.push_back(mk(1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0));
        vq.push_back(mk(1'b0, 5'd0,  32'h0,         32'hFFFF_FFFF));
        vq.push_back(mk(1'b1, 5'd15, 32'h1234_5678, 32'h0));
        vq.push_back(mk(1'b0, 5'd15, 32'h0,         32'h1234_5678));
        vq.push_back(mk(1'b1, 5'd17, 32'hFFFF_A50F, 32'h0));
        vq.push_back(mk(1'b0, 5'd17, 32'h0,         32'h0000_A50F));
        vq.push_back(mk(1'b1, 5'd16, 32'h0000_0003, 32'h0));
        vq.push_back(mk(1'b0, 5'd16, 32'h0,         32'h0000_0003));
        vq.push_back(mk(1'b1, 5'd16, 32'h0000_0000, 32'h0));
        vq.push_back(mk(1'b0, 5'd16, 32'h0,         32'h0000_0000));
        vq.push_back(mk(1'b1, 5'd31, 32'h0000_FFFF, 32'h0));
        vq.push_back(mk(1'b0, 5'd31, 32'h0,         32'h0));
        vq.push_back(mk(1'b1, 5'd18, 32'hDEAD_BEEF, 32'h0));
        vq.push_back(mk(1'b0, 5'd18, 32'h0,         32'h0));
        vq.push_back(mk(1'b0, 5'd6,  32'h0,         32'h0000_1000));
`ifndef CODE_PATCH_CFG_LOCK_EN
        vq.push_back(mk(1'b1, 5'd16, 32'h0000_000B, 32'h0));
        vq.push_back(mk(1'b0, 5'd16, 32'h0,         32'h0000_0003));
        vq.push_back(mk(1'b1, 5'd16, 32'h0000_0000, 32'h0));
`endif

        // Reset with a request held: nothing may respond.
        rst_ni = 1'b0; cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; si_read = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ack",     64'(cfg_ack),        64'd0);
        check("rst_rdata",   64'(cfg_rdata),      64'd0);
        check("rst_pending", 64'(commit_pending), 64'd0);
        check("rst_done",    64'(commit_done),    64'd0);
        check_active("rst");
        cfg_req = 1'b0;
        rst_ni  = 1'b1;
        @(negedge clk);
        do_read(5'd0, 32'd0, "post_rst_read0");

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].we) do_write(vq[i].addr, vq[i].wdata);
            else          do_read(vq[i].addr, vq[i].exp, $sformatf("vec%0d", i));
        end
        check_active("after_table");

        // Basic commit with the bus idle.
        si_read = 1'b0;
        do_write(5'd6,  32'h0000_1000);
        do_write(5'd7,  32'h0000_CAFE);
        do_write(5'd17, 32'h0000_0008);
        start = done_cnt;
        do_write(5'd16, 32'h0000_0007);
        ack_c = last_ack_cyc;
        model_commit();
        wait_done(start, 20, "t2_done");
        check("t2_latency",  64'(done_cyc - ack_c), 64'd3);
        check("t2_addr3",    64'(ctl_pat_addr[3]), 64'h1000);
        check("t2_data3",    64'(ctl_pat_data[3]), 64'hCAFE);
        check("t2_pen",      64'(ctl_pat_pen),     64'h08);
        check("t2_gen",      64'(pat_gen),         64'd1);
        check("t2_aod",      64'(addr_or_data),    64'd1);
        check("t2_pending",  64'(commit_pending),  64'd0);
        check_active("t2");

        // Busy read bus never quiet for two cycles: commit must wait.
        si_read = 1'b1;
        do_write(5'd11, 32'h0000_BEEF);
        start = done_cnt;
        do_write(5'd16, 32'h0000_0005);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t3_pending", 64'(commit_pending), 64'd1);
            si_read = (k % 2 == 1);
        end
        check("t3_no_done", 64'(done_cnt - start), 64'd0);
        @(negedge clk);
        si_read = 1'b0;
        fall_c = cyc;
        model_commit();
        wait_done(start, 20, "t3_done");
        check("t3_latency", 64'(done_cyc - fall_c), 64'd3);
        check("t3_data5",   64'(ctl_pat_data[5]),   64'hBEEF);
        check("t3_gen_aod", 64'({pat_gen, addr_or_data}), 64'b10);
        check_active("t3");

        // Shadow write and a second COMMIT while waiting: one commit carrying both.
        si_read = 1'b1;
        start = done_cnt;
        do_write(5'd16, 32'h0000_0004);
        do_write(5'd1,  32'h0000_0055);
        do_read(5'd16, 32'h0000_0004, "t4_ctrl_pending");
        do_write(5'd16, 32'h0000_0007);
        @(negedge clk);
        si_read = 1'b0;
        model_commit();
        wait_done(start, 20, "t4_done");
        repeat (8) begin
            @(negedge clk);
            #1;
        end
        check("t4_single_pulse", 64'(done_cnt - start), 64'd1);
        check("t4_data0",        64'(ctl_pat_data[0]),  64'h55);
        check_active("t4");

        // Write accepted on the COMMIT edge reaches shadow only.
        start = done_cnt;
        do_write(5'd16, 32'h0000_0007);
        ack_c = last_ack_cyc;
        model_commit();
        @(negedge clk);
        do_write(5'd3, 32'h0000_0077);
        wait_done(start, 20, "t6_done");
        check("t6_latency", 64'(done_cyc - ack_c), 64'd3);
        check("t6_data1_active", 64'(ctl_pat_data[1]), 64'd0);
        do_read(5'd3, 32'h0000_0077, "t6_data1_shadow");
        check_active("t6");

        // Randomized accesses against the model, each round ending in a commit.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 25; k++) begin
                ra = 5'($urandom_range(0, 31));
                rw = $urandom;
                if (ra == 5'd16) rw = rw & 32'h3;
                si_read = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) do_write(ra, rw);
                else do_read(ra, model_read(ra, 1'b0), "rand_read");
            end
            check_active("rand_hold");
            si_read = 1'b0;
            start = done_cnt;
            do_write(5'd16, 32'($urandom_range(0, 3)) | 32'h4);
            model_commit();
            wait_done(start, 20, "rand_done");
            check_active("rand_commit");
        end

        // Reset while waiting for quiet: the commit is dropped.
        si_read = 1'b1;
        do_write(5'd16, 32'h0000_0007);
        @(negedge clk);
        check("t5_pending_before", 64'(commit_pending), 64'd1);
        start = done_cnt;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni  = 1'b1;
        si_read = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        #1;
        check("t5_pending_after", 64'(commit_pending), 64'd0);
        check("t5_no_done",       64'(done_cnt - start), 64'd0);
        check_active("t5");
        do_read(5'd16, 32'h0, "t5_ctrl");

`ifdef CODE_PATCH_CFG_LOCK_EN
        start = done_cnt;
        do_write(5'd16, 32'h0000_000D);
        model_commit();
        do_write(5'd0,  32'h0000_AAAA);
        do_write(5'd16, 32'h0000_0000);
        wait_done(start, 20, "lock_done");
        check("lock_gen", 64'(pat_gen), 64'd1);
        do_read(5'd0,  32'h0, "lock_addr0");
        do_read(5'd16, 32'h9, "lock_ctrl");
        check_active("lock");
`else
        do_write(5'd16, 32'h0000_0008);
        do_read(5'd16, 32'h0, "nolock_ctrl");
        do_write(5'd0, 32'h0000_AAAA);
        do_read(5'd0, 32'h0000_AAAA, "nolock_addr0");
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/code_patch_cfg_ctrl.md
Name: code_patch_cfg_ctrl

Overview:
Configuration controller for the code patch datapath. Holds a shadow bank of substitution registers (patch address, patch data, per-entry enable and no-propagate bits) plus the global mode bits, all written over a simple req/ack register port. It commits the shadow bank atomically to the active outputs that drive the patch core. A commit happens only after the slave read bus has been quiet for a programmable number of cycles, so a transaction is never patched with half-updated tables.

Parameters:
ADDR_WIDTH, 32, width of patched bus address
DATA_WIDTH, 32, width of patched bus data
NUM_REGS, 8, number of substitution entries; legal range 1..16 (2*NUM_REGS <= SUB_REGS_DATA_WIDTH)
SUB_REGS_DATA_WIDTH, max(ADDR_WIDTH,DATA_WIDTH), width of patch data entries and of the config data port
QUIET_CYCLES, 2, consecutive cycles of si_read_i low required before a commit; legal range 1..255
CFG_AW, $clog2(2*NUM_REGS+2), config word-address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
cfg_req_i  in  1  config access request
cfg_we_i  in  1  1 = write, 0 = read
cfg_addr_i  in  CFG_AW  config word index
cfg_wdata_i  in  SUB_REGS_DATA_WIDTH  write data
cfg_rdata_o  out  SUB_REGS_DATA_WIDTH  read data, valid with cfg_ack_o
cfg_ack_o  out  1  one-cycle access acknowledge
si_read_i  in  1  slave read active on the patched bus
ctl_pat_addr_o  out  ADDR_WIDTH x NUM_REGS  active patch addresses
ctl_pat_data_o  out  SUB_REGS_DATA_WIDTH x NUM_REGS  active patch data
ctl_pat_pen_o  out  NUM_REGS  active per-entry enables
ctl_pat_nopg_o  out  NUM_REGS  active per-entry no-propagate bits
cfg_pat_gen_o  out  1  active global patch enable
cfg_addr_or_data_o  out  1  active mode: 0 = address patch, 1 = data patch
commit_pending_o  out  1  commit requested, not yet applied
commit_done_o  out  1  one-cycle pulse in the cycle the active outputs update

Behaviour:
- Reset (rst_ni low at a clock edge): all shadow and active registers 0, all outputs 0, FSM returns to IDLE, pending commit dropped, quiet counter cleared.
- Register map, by word index:
  - 2*i: shadow ADDR[i]. Writes take cfg_wdata_i[ADDR_WIDTH-1:0]; reads zero-extend.
  - 2*i+1: shadow DATA[i].
  - 2*NUM_REGS: CTRL. bit0 pat_gen, bit1 addr_or_data, bit2 COMMIT (write 1 requests a commit; reads return commit_pending_o).
  - 2*NUM_REGS+1: ENABLE. [NUM_REGS-1:0] pen, [2*NUM_REGS-1:NUM_REGS] nopg.
  - Other indices: reads return 0, writes are ignored; both are still acked.
- Handshake:
  - cfg_ack_o is registered. It goes high one cycle after cfg_req_i is sampled while cfg_ack_o is low.
  - cfg_req_i sampled while cfg_ack_o is high is a new access only if the requester re-drove it. Requesters drop req in the ack cycle.
  - Write data lands in shadow on the request edge. cfg_rdata_o is valid only while ack is high and is 0 otherwise.
- Reads always return shadow contents, never active contents.
- FSM:
  - IDLE -> WAIT_QUIET on a COMMIT write. commit_pending_o goes high the next cycle.
  - WAIT_QUIET: the quiet counter increments each cycle si_read_i is low and clears to 0 whenever si_read_i is high. On reaching QUIET_CYCLES -> COMMIT.
  - COMMIT (one cycle): copy all shadow registers to the active outputs (visible the following cycle), pulse commit_done_o, clear pending, -> IDLE.
- Boundary conditions:
  - COMMIT write while already pending: ignored, no restart of the quiet count.
  - Shadow write during WAIT_QUIET: accepted and included in the commit.
  - Shadow write in the COMMIT cycle itself: lands in shadow only. The copy uses pre-write register values.
  - A CTRL write carrying COMMIT=1 updates pat_gen and addr_or_data in shadow first, so those new values are committed.
  - si_read_i held high indefinitely: the commit stays pending with no timeout. Active outputs are never partially updated.
- Active outputs change only in the cycle after COMMIT.

Optional Feature:
Macro CODE_PATCH_CFG_LOCK_EN.
- Defined: CTRL bit3 is LOCK, a sticky bit cleared only by reset. Once set, all writes to indices 0..2*NUM_REGS+1 are ignored but still acked, and CTRL bit3 reads 1. A commit already pending when LOCK is set still completes. The LOCK write may carry COMMIT=1 in the same access.
- Not defined: bit3 reads 0, writes to it have no effect, and no lock logic is present.

Test Plan:
1. Reset: hold rst_ni low 3 cycles with req asserted -> all outputs 0, no ack. Release; read index 0 -> ack 1 cycle later, rdata 0.
2. Write ADDR[3]=0x1000, DATA[3]=0xCAFE, ENABLE=0x0008, CTRL=0x7 with si_read_i low -> commit_done_o 3 cycles after the CTRL ack (2 quiet cycles + COMMIT). Then ctl_pat_addr_o[3]=0x1000, ctl_pat_data_o[3]=0xCAFE, pen=0x08, pat_gen=1, addr_or_data=1.
3. Commit with si_read_i toggling high every 2nd cycle for 20 cycles, then low -> pending stays 1 and outputs unchanged throughout; commit_done_o exactly 3 cycles after si_read_i last falls.
4. During WAIT_QUIET, write DATA[0]=0x55 and issue a second COMMIT -> a single commit_done_o pulse, and ctl_pat_data_o[0]=0x55 after it.
5. Access to index 31 (write 0xFFFF, then read) -> both acked, read returns 0, no state change. Reset asserted during WAIT_QUIET -> pending 0 and no commit after release.
6. (LOCK_EN) Write CTRL=0xD (pat_gen, COMMIT, LOCK), then write ADDR[0]=0xAAAA -> commit completes with pat_gen=1; ADDR[0] reads 0; CTRL reads bit3=1.
